// File: rtl/scpu_seq_ctrl.sv
// scpu_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the SCPU
// datapath, with a retired-instruction counter.
// Optional feature: define SEQ_TRAP_EN to send unknown opcodes to a TRAP state
// that waits for trap_clr; otherwise they retire as NOPs.
module scpu_seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             imem_ack,
    input  logic [6:0]       inst_op,
    input  logic             dmem_ack,
    input  logic             br_taken,
    input  logic             trap_clr,
    output logic             imem_req,
    output logic             ir_we,
    output logic [2:0]       imm_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             mem_to_reg,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef SEQ_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    // Raw (ungated) strobes from the FSM; reset masking is applied at the ports.
    logic       imem_req_c, ir_we_c, dmem_req_c, dmem_we_c;
    logic       reg_we_c, mem_to_reg_c, pc_we_c, trap_c, retire;
    logic [2:0] imm_sel_c, imm_dec;
    logic [1:0] pc_src_c;

    logic is_imm, is_load, is_jalr, is_lui, is_jal, is_branch, is_store, op_known;

    // Opcode class flags and immediate-type decode from the latched opcode.
    always_comb begin
        is_imm    = (op_q == OP_IMM);
        is_load   = (op_q == OP_LOAD);
        is_jalr   = (op_q == OP_JALR);
        is_lui    = (op_q == OP_LUI);
        is_jal    = (op_q == OP_JAL);
        is_branch = (op_q == OP_BRANCH);
        is_store  = (op_q == OP_STORE);
        op_known  = is_imm | is_load | is_jalr | is_lui | is_jal | is_branch | is_store;
        imm_dec   = 3'd0;
        if (is_imm || is_load || is_jalr) imm_dec = 3'd1;
        else if (is_lui)                  imm_dec = 3'd2;
        else if (is_jal)                  imm_dec = 3'd3;
        else if (is_branch)               imm_dec = 3'd4;
        else if (is_store)                imm_dec = 3'd5;
    end

    // Next-state, opcode latch, strobe and retire decode.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        imem_req_c   = 1'b0;
        ir_we_c      = 1'b0;
        imm_sel_c    = 3'd0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        reg_we_c     = 1'b0;
        mem_to_reg_c = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'd0;
        trap_c       = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    op_d    = inst_op;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_sel_c = imm_dec;
`ifdef SEQ_TRAP_EN
                if (!op_known) state_d = S_TRAP;
                else           state_d = S_EXEC;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                imm_sel_c = imm_dec;
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = {1'b0, br_taken};
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                imm_sel_c  = imm_dec;
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                imm_sel_c    = imm_dec;
                pc_we_c      = 1'b1;
                pc_src_c     = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
                // Unknown opcodes reach here as NOPs and must not write the register file.
                reg_we_c     = is_imm | is_lui | is_load | is_jal | is_jalr;
                mem_to_reg_c = is_load;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
`ifdef SEQ_TRAP_EN
            S_TRAP: begin
                trap_c = 1'b1;
                if (trap_clr) begin
                    pc_we_c = 1'b1;
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_FETCH;
        endcase
        instret_d = instret_q + CNT_W'(retire);
    end

    // State, opcode and counter registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            instret_q <= instret_d;
        end
    end

    // All strobes are forced low while reset is held, including the FETCH request.
    assign imem_req   = imem_req_c & rstn;
    assign ir_we      = ir_we_c & rstn;
    assign imm_sel    = imm_sel_c & {3{rstn}};
    assign dmem_req   = dmem_req_c & rstn;
    assign dmem_we    = dmem_we_c & rstn;
    assign reg_we     = reg_we_c & rstn;
    assign mem_to_reg = mem_to_reg_c & rstn;
    assign pc_we      = pc_we_c & rstn;
    assign pc_src     = pc_src_c & {2{rstn}};
    assign instret    = instret_q;

`ifdef SEQ_TRAP_EN
    assign trap = trap_c & rstn;
`else
    // Without the trap feature the acknowledge input has no function.
    logic unused_trap;
    assign unused_trap = trap_c | trap_clr;
    assign trap        = 1'b0;
`endif

endmodule
